// File: rtl/ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : ram_dp
//  Purpose  : 1R/W + 1R data memory with address-window decode, error flag,
//             and optional post-reset clear sequencer (macro RAM_DP_CLR_EN).
//  Revision : 1.0
// ============================================================================
module ram_dp #(
  parameter int          DW     = 16,
  parameter int          AW     = 13,
  parameter int          RAM_AW = 7,
  parameter int unsigned BASE   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   a_din,
  input  logic [AW-1:0]   a_addr,
  input  logic            a_we,
  input  logic [DW/8-1:0] a_be,
  output logic [DW-1:0]   a_dout,
  output logic            a_err,
  input  logic [AW-1:0]   b_addr,
  output logic [DW-1:0]   b_dout,
  output logic            busy
);

  localparam int          NB     = DW / 8;
  localparam int          DEPTH  = 2 ** RAM_AW;
  localparam logic [AW-1:0] BASE_W = AW'(BASE);

  logic [DW-1:0]     mem [DEPTH];
  logic [RAM_AW-1:0] a_addr_r;
  logic [RAM_AW-1:0] b_addr_r;
  logic [RAM_AW-1:0] a_idx;
  logic              hit_a;
  logic              wr_en;
  logic              clr_we;
  logic [RAM_AW-1:0] clr_cnt;
  logic              unused_b_hi;

  // Shifting rather than slicing keeps the decode legal when RAM_AW == AW.
  assign hit_a       = ((a_addr >> RAM_AW) == BASE_W);
  assign a_idx       = a_addr[RAM_AW-1:0];
  assign wr_en       = a_we & hit_a & ~busy;
  assign unused_b_hi = ^(b_addr >> RAM_AW);

`ifdef RAM_DP_CLR_EN
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [RAM_AW-1:0] CLR_LAST = '1;

  state_t            state;
  state_t            state_nxt;
  logic [RAM_AW-1:0] clr_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    case (state)
      CLEAR: begin
        clr_we      = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == CLEAR);
`else
  assign clr_we  = 1'b0;
  assign clr_cnt = '0;
  assign busy    = 1'b0;
`endif

  // Clear has priority; busy already blocks port A while clearing.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) begin
          mem[a_idx][8*i +: 8] <= a_din[8*i +: 8];
        end
      end
    end
  end

  // Read address is held during writes so a_dout keeps tracking the last read.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_addr_r <= '0;
      b_addr_r <= '0;
      a_err    <= 1'b0;
    end else begin
      if (!a_we) begin
        a_addr_r <= a_idx;
      end
      b_addr_r <= b_addr[RAM_AW-1:0];
      a_err    <= ~hit_a;
    end
  end

  assign a_dout = mem[a_addr_r];
  assign b_dout = mem[b_addr_r];

endmodule
`default_nettype wire

// File: tb/tb_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_dp
//  Purpose  : Directed table-driven bench for ram_dp (DW=16, AW=13, RAM_AW=7).
//  Revision : 1.0
// ============================================================================
module tb_ram_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_din;
  logic [12:0] a_addr;
  logic        a_we;
  logic [1:0]  a_be;
  logic [15:0] a_dout;
  logic        a_err;
  logic [12:0] b_addr;
  logic [15:0] b_dout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ram_dp #(.DW(16), .AW(13), .RAM_AW(7), .BASE(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_din  (a_din),
    .a_addr (a_addr),
    .a_we   (a_we),
    .a_be   (a_be),
    .a_dout (a_dout),
    .a_err  (a_err),
    .b_addr (b_addr),
    .b_dout (b_dout),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [15:0] din;
    logic [1:0]  be;
    logic [12:0] baddr;
    logic [15:0] exp_a;
    logic        exp_err;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [12:0] addr, input logic [15:0] din,
                       input logic [1:0] be, input logic [12:0] baddr);
    a_we   = we;
    a_addr = addr;
    a_din  = din;
    a_be   = be;
    b_addr = baddr;
  endtask

  // Steps with current inputs until busy drops; n is the number of edges taken.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;

    //            we    addr       din       be     baddr      exp_a     err   exp_b
    vecs[0]  = '{1'b1, 13'd0,    16'h1234, 2'b11, 13'd0,   16'h1234, 1'b0, 16'h1234};
    vecs[1]  = '{1'b1, 13'd5,    16'hABCD, 2'b11, 13'd5,   16'h1234, 1'b0, 16'hABCD};
    vecs[2]  = '{1'b0, 13'd5,    16'h0000, 2'b00, 13'd0,   16'hABCD, 1'b0, 16'h1234};
    vecs[3]  = '{1'b1, 13'd5,    16'h1200, 2'b10, 13'd5,   16'h12CD, 1'b0, 16'h12CD};
    vecs[4]  = '{1'b0, 13'd5,    16'h0000, 2'b00, 13'd5,   16'h12CD, 1'b0, 16'h12CD};
    vecs[5]  = '{1'b1, 13'd5,    16'hFFFF, 2'b00, 13'd5,   16'h12CD, 1'b0, 16'h12CD};
    vecs[6]  = '{1'b1, 13'h0085, 16'hFFFF, 2'b11, 13'd5,   16'h12CD, 1'b1, 16'h12CD};
    vecs[7]  = '{1'b0, 13'd5,    16'h0000, 2'b00, 13'd5,   16'h12CD, 1'b0, 16'h12CD};
    vecs[8]  = '{1'b0, 13'h1005, 16'h0000, 2'b00, 13'd0,   16'h12CD, 1'b1, 16'h1234};
    vecs[9]  = '{1'b1, 13'd9,    16'h5555, 2'b11, 13'd9,   16'h12CD, 1'b0, 16'h5555};
    vecs[10] = '{1'b1, 13'd9,    16'h00AA, 2'b01, 13'd9,   16'h12CD, 1'b0, 16'h55AA};
    vecs[11] = '{1'b0, 13'd9,    16'h0000, 2'b00, 13'd5,   16'h55AA, 1'b0, 16'h12CD};
    vecs[12] = '{1'b1, 13'd127,  16'hBEEF, 2'b11, 13'd127, 16'h55AA, 1'b0, 16'hBEEF};
    vecs[13] = '{1'b0, 13'd127,  16'h0000, 2'b00, 13'd9,   16'hBEEF, 1'b0, 16'h55AA};
    vecs[14] = '{1'b1, 13'h0C7F, 16'h0000, 2'b11, 13'd127, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[15] = '{1'b0, 13'h0C05, 16'h0000, 2'b00, 13'd5,   16'h12CD, 1'b1, 16'h12CD};
    vecs[16] = '{1'b0, 13'd0,    16'h0000, 2'b00, 13'd0,   16'h1234, 1'b0, 16'h1234};

    rst = 1'b1;
    drive(1'b0, 13'd0, 16'h0, 2'b00, 13'd0);
    step();
    step();
    check("reset_a_err", {31'd0, a_err}, 32'd0);
`ifdef RAM_DP_CLR_EN
    check("reset_busy", {31'd0, busy}, 32'd1);
`else
    check("reset_busy", {31'd0, busy}, 32'd0);
`endif
    rst = 1'b0;
    wait_idle(n);
`ifdef RAM_DP_CLR_EN
    check("initial_clear_len", n, 32'd128);
`else
    check("initial_clear_len", n, 32'd0);
`endif

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].be, vecs[i].baddr);
      step();
      check($sformatf("v%0d_a_dout", i), {16'd0, a_dout}, {16'd0, vecs[i].exp_a});
      check($sformatf("v%0d_a_err", i), {31'd0, a_err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_b_dout", i), {16'd0, b_dout}, {16'd0, vecs[i].exp_b});
    end

    // Reset overrides a pending miss and returns both read pointers to word 0.
    drive(1'b0, 13'h1005, 16'h0, 2'b00, 13'd127);
    step();
    rst = 1'b1;
    step();
    check("rst_a_err", {31'd0, a_err}, 32'd0);
    check("rst_a_dout", {16'd0, a_dout}, 32'h1234);
    check("rst_b_dout", {16'd0, b_dout}, 32'h1234);
    rst = 1'b0;

`ifdef RAM_DP_CLR_EN
    check("clr_busy_after_rst", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 300) begin
      drive(1'b1, (n == 10) ? 13'h0085 : 13'd0, 16'h7777, 2'b11,
            (n < 60) ? 13'd127 : 13'd2);
      step();
      n++;
      if (n == 5)  check("clr_not_yet_127", {16'd0, b_dout}, 32'hBEEF);
      if (n == 11) check("clr_err_reported", {31'd0, a_err}, 32'd1);
      if (n == 70) check("clr_word2_zero", {16'd0, b_dout}, 32'd0);
    end
    check("clr_busy_len", n, 32'd128);
    drive(1'b0, 13'd0, 16'h0, 2'b00, 13'd127);
    step();
    check("clr_b127_zero", {16'd0, b_dout}, 32'd0);
    check("clr_write_dropped", {16'd0, a_dout}, 32'd0);
    check("clr_idle_busy", {31'd0, busy}, 32'd0);
    drive(1'b1, 13'd127, 16'hBEEF, 2'b11, 13'd127);
    step();
    check("post_clr_write", {16'd0, b_dout}, 32'hBEEF);

    // Second reset 40 cycles into a clear must restart the full sweep.
    drive(1'b0, 13'd0, 16'h0, 2'b00, 13'd127);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) step();
    check("mid_clr_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_idle(n);
    check("restart_clr_len", n, 32'd128);
    step();
    check("restart_b127_zero", {16'd0, b_dout}, 32'd0);
`else
    check("noclr_busy", {31'd0, busy}, 32'd0);
    drive(1'b1, 13'd3, 16'h3333, 2'b11, 13'd3);
    step();
    check("noclr_first_write", {16'd0, b_dout}, 32'h3333);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
